// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants for the signed up/down limit counter
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising-edge detector against a one-clock history flop
module edge_detect (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic x_i,
  output logic rise_o
);

  logic x_q;
  logic x_d;

  always_comb begin
    x_d = x_i;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      x_q <= 1'b0;
    end else begin
      x_q <= x_d;
    end
  end

  assign rise_o = x_i & ~x_q;

endmodule

// File: rtl/counter_ext.sv
// rtl/counter_ext.sv - signed up/down event counter with programmable limits,
// wrap or saturate, and a carry pulse on every limit crossing
module counter_ext
  import counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             enable_i,
  input  logic             trigger_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] START,
  input  logic             START_WSTB,
  input  logic [WIDTH-1:0] STEP,
  input  logic             STEP_WSTB,
  input  logic [WIDTH-1:0] MIN,
  input  logic             MIN_WSTB,
  input  logic [WIDTH-1:0] MAX,
  input  logic             MAX_WSTB,
  input  logic             MODE,
  output logic [WIDTH-1:0] out_o,
  output logic             carry_o
);

  localparam int NW = WIDTH + 2;

  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;

  logic en_rise;
  logic trig_rise;

  // Two guard bits keep out +/- step and the wrap span exact for full-range limits.
  logic signed [NW-1:0] cur_w, step_w, min_w, max_w, span_w, n_w;

  edge_detect u_en_edge (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .x_i      (enable_i),
    .rise_o   (en_rise)
  );

  edge_detect u_trig_edge (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .x_i      (trigger_i),
    .rise_o   (trig_rise)
  );

  always_comb begin
    out_d   = out_q;
    carry_d = 1'b0;
    step_d  = STEP_WSTB ? STEP : step_q;
    min_d   = MIN_WSTB  ? MIN  : min_q;
    max_d   = MAX_WSTB  ? MAX  : max_q;

    cur_w  = {{2{out_q[WIDTH-1]}}, out_q};
    step_w = {2'b00, step_q};
    min_w  = {{2{min_q[WIDTH-1]}}, min_q};
    max_w  = {{2{max_q[WIDTH-1]}}, max_q};
    span_w = max_w - min_w + NW'(1);
    n_w    = (dir_i == DIR_UP) ? (cur_w + step_w) : (cur_w - step_w);

    if (en_rise || START_WSTB) begin
      out_d = START;
    end else if (trig_rise && enable_i) begin
      if (dir_i == DIR_UP && n_w > max_w) begin
        carry_d = 1'b1;
        out_d   = (MODE == MODE_WRAP) ? WIDTH'(n_w - span_w) : max_q;
      end else if (dir_i == DIR_DOWN && n_w < min_w) begin
        carry_d = 1'b1;
        out_d   = (MODE == MODE_SAT) ? min_q : WIDTH'(n_w + span_w);
      end else begin
        out_d = n_w[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      step_q  <= WIDTH'(1);
      min_q   <= {1'b1, {(WIDTH-1){1'b0}}};
      max_q   <= {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      step_q  <= step_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  assign out_o   = out_q;
  assign carry_o = carry_q;

endmodule

// File: tb/tb_counter_ext.sv
// tb/tb_counter_ext.sv - scoreboard bench for counter_ext
module tb_counter_ext;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        enable_i;
  logic        trigger_i;
  logic        dir_i;
  logic [31:0] START;
  logic        START_WSTB;
  logic [31:0] STEP;
  logic        STEP_WSTB;
  logic [31:0] MIN;
  logic        MIN_WSTB;
  logic [31:0] MAX;
  logic        MAX_WSTB;
  logic        MODE;
  logic [31:0] out_o;
  logic        carry_o;

  typedef struct {
    logic [31:0] out;
    logic        carry;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  counter_ext #(.WIDTH(32)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .enable_i   (enable_i),
    .trigger_i  (trigger_i),
    .dir_i      (dir_i),
    .START      (START),
    .START_WSTB (START_WSTB),
    .STEP       (STEP),
    .STEP_WSTB  (STEP_WSTB),
    .MIN        (MIN),
    .MIN_WSTB   (MIN_WSTB),
    .MAX        (MAX),
    .MAX_WSTB   (MAX_WSTB),
    .MODE       (MODE),
    .out_o      (out_o),
    .carry_o    (carry_o)
  );

  // Raise trigger, queue the expected result, and return just after the sampling edge.
  task automatic trig(input logic d, input logic [31:0] eo, input logic ec);
    @(negedge clk_i);
    dir_i     = d;
    trigger_i = 1'b1;
    sb.push_back('{eo, ec});
    @(posedge clk_i);
    #1;
  endtask

  task automatic untrig;
    @(negedge clk_i);
    trigger_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] exp_seq [3];
    exp_seq = '{32'd1, 32'd2, 32'd3};
    reset_ni = 1'b0; enable_i = 1'b0; trigger_i = 1'b0; dir_i = 1'b0;
    START = '0; START_WSTB = 1'b0; STEP = '0; STEP_WSTB = 1'b0;
    MIN = '0; MIN_WSTB = 1'b0; MAX = '0; MAX_WSTB = 1'b0; MODE = 1'b0;
    sb.push_back('{32'd0, 1'b0});
    @(negedge clk_i);
    e = sb.pop_front();
    n_cmp++;
    if (out_o !== e.out || carry_o !== e.carry) begin
      n_err++;
      $display("FAIL reset_state: out_o=%0d carry_o=%b, expected out_o=%0d carry_o=%b", out_o, carry_o, e.out, e.carry);
    end
    reset_ni = 1'b1;
    enable_i = 1'b1;
    trig(1'b0, 32'd1, 1'b0);
    untrig;
    trig(1'b0, 32'd2, 1'b0);
    untrig;
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.out !== 32'(i + 1)) begin
        n_err++;
        $display("FAIL reset_precount_queue: entry=%0d expected=%0d", e.out, i + 1);
      end
    end
    n_cmp++;
    if (out_o !== 32'd2) begin
      n_err++;
      $display("FAIL reset_precount: out_o=%0d, expected out_o=2", out_o);
    end
    @(negedge clk_i);
    #2;
    reset_ni = 1'b0;
    sb.push_back('{32'd0, 1'b0});
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (out_o !== e.out || carry_o !== e.carry) begin
      n_err++;
      $display("FAIL reset_midcount: out_o=%0d carry_o=%b, expected out_o=%0d carry_o=%b", out_o, carry_o, e.out, e.carry);
    end
    @(negedge clk_i);
    reset_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      trig(1'b0, exp_seq[i], 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if (out_o !== e.out || carry_o !== e.carry) begin
        n_err++;
        $display("FAIL reset_count%0d: out_o=%0d carry_o=%b, expected out_o=%0d carry_o=%b", i, out_o, carry_o, e.out, e.carry);
      end
      untrig;
    end
  endtask

  task automatic test_up_wrap;
    logic [31:0] eo [3];
    logic        ec [3];
    eo = '{32'd4, 32'd8, 32'd2};
    ec = '{1'b0, 1'b0, 1'b1};
    @(negedge clk_i);
    enable_i = 1'b0; MODE = 1'b0;
    MIN = 32'd0; MIN_WSTB = 1'b1; MAX = 32'd9; MAX_WSTB = 1'b1;
    STEP = 32'd4; STEP_WSTB = 1'b1; START = 32'd0;
    @(negedge clk_i);
    MIN_WSTB = 1'b0; MAX_WSTB = 1'b0; STEP_WSTB = 1'b0;
    enable_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      trig(1'b0, eo[i], ec[i]);
      e = sb.pop_front();
      n_cmp++;
      if (out_o !== e.out || carry_o !== e.carry) begin
        n_err++;
        $display("FAIL up_wrap%0d: out_o=%0d carry_o=%b, expected out_o=%0d carry_o=%b", i, out_o, carry_o, e.out, e.carry);
      end
      untrig;
    end
    n_cmp++;
    if (carry_o !== 1'b0 || out_o !== 32'd2) begin
      n_err++;
      $display("FAIL up_wrap_after: out_o=%0d carry_o=%b, expected out_o=2 carry_o=0", out_o, carry_o);
    end
  endtask

  task automatic test_down_sat;
    logic ec [3];
    ec = '{1'b0, 1'b1, 1'b1};
    @(negedge clk_i);
    MODE = 1'b1;
    MIN = -32'sd5; MIN_WSTB = 1'b1;
    STEP = 32'd2; STEP_WSTB = 1'b1;
    START = -32'sd3; START_WSTB = 1'b1;
    @(negedge clk_i);
    MIN_WSTB = 1'b0; STEP_WSTB = 1'b0; START_WSTB = 1'b0;
    n_cmp++;
    if (out_o !== 32'hFFFF_FFFD) begin
      n_err++;
      $display("FAIL down_sat_load: out_o=%0d, expected out_o=-3", $signed(out_o));
    end
    for (int i = 0; i < 3; i++) begin
      trig(1'b1, -32'sd5, ec[i]);
      e = sb.pop_front();
      n_cmp++;
      if (out_o !== e.out || carry_o !== e.carry) begin
        n_err++;
        $display("FAIL down_sat%0d: out_o=%0d carry_o=%b, expected out_o=%0d carry_o=%b", i, $signed(out_o), carry_o, $signed(e.out), e.carry);
      end
      untrig;
      n_cmp++;
      if (carry_o !== 1'b0) begin
        n_err++;
        $display("FAIL down_sat_gap%0d: carry_o=%b, expected carry_o=0", i, carry_o);
      end
    end
  endtask

  task automatic test_priority;
    @(negedge clk_i);
    enable_i = 1'b0; MODE = 1'b0; dir_i = 1'b0;
    @(negedge clk_i);
    START = 32'd100; enable_i = 1'b1; trigger_i = 1'b1;
    sb.push_back('{32'd100, 1'b0});
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (out_o !== e.out || carry_o !== e.carry) begin
      n_err++;
      $display("FAIL prio_reload: out_o=%0d carry_o=%b, expected out_o=%0d carry_o=%b", out_o, carry_o, e.out, e.carry);
    end
    @(negedge clk_i);
    trigger_i = 1'b0; enable_i = 1'b0;
    @(negedge clk_i);
    START = 32'd55; START_WSTB = 1'b1;
    sb.push_back('{32'd55, 1'b0});
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (out_o !== e.out || carry_o !== e.carry) begin
      n_err++;
      $display("FAIL prio_wstb: out_o=%0d carry_o=%b, expected out_o=%0d carry_o=%b", out_o, carry_o, e.out, e.carry);
    end
    @(negedge clk_i);
    START_WSTB = 1'b0;
  endtask

  task automatic test_full_range;
    @(negedge clk_i);
    reset_ni = 1'b0; START = 32'h7FFF_FFFF; MODE = 1'b0; enable_i = 1'b1;
    @(negedge clk_i);
    reset_ni = 1'b1;
    sb.push_back('{32'h7FFF_FFFF, 1'b0});
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (out_o !== e.out || carry_o !== e.carry) begin
      n_err++;
      $display("FAIL full_load: out_o=%h carry_o=%b, expected out_o=%h carry_o=%b", out_o, carry_o, e.out, e.carry);
    end
    trig(1'b0, 32'h8000_0000, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if (out_o !== e.out || carry_o !== e.carry) begin
      n_err++;
      $display("FAIL full_wrap: out_o=%h carry_o=%b, expected out_o=%h carry_o=%b", out_o, carry_o, e.out, e.carry);
    end
    untrig;
  endtask

  task automatic test_enable_low;
    @(negedge clk_i);
    enable_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      trig(i[0], 32'h8000_0000, 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if (out_o !== e.out || carry_o !== e.carry) begin
        n_err++;
        $display("FAIL enable_low%0d: out_o=%h carry_o=%b, expected out_o=%h carry_o=%b", i, out_o, carry_o, e.out, e.carry);
      end
      untrig;
    end
  endtask

  initial begin
    test_reset;
    test_up_wrap;
    test_down_sat;
    test_priority;
    test_full_range;
    test_enable_low;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
